// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared definitions for the sequential restoring divider.
//   - default dividend/quotient and divisor/remainder widths
//   - FSM state type and encoding
//   - counter width helper ($clog2 of the dividend width)
package seq_div_pkg;

  localparam int unsigned NW_DEFAULT = 16;
  localparam int unsigned DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Iteration counter width; kept at least 1 bit so a 1-bit dividend still builds.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   rem      - current partial remainder (D_W bits, always < divisor)
//   msb      - next dividend bit shifted into the remainder
//   divisor  - divisor (D_W bits)
//   rem_next - partial remainder after the step
//   q_bit    - quotient bit produced by the step
module div_step #(
  parameter int unsigned D_W = 8
) (
  input  logic [D_W-1:0] rem,
  input  logic           msb,
  input  logic [D_W-1:0] divisor,
  output logic [D_W-1:0] rem_next,
  output logic           q_bit
);

  logic [D_W:0] shifted;

  always_comb begin
    shifted  = {rem, msb};
    q_bit    = (shifted >= {1'b0, divisor});
    // When the subtraction is taken the true difference is < divisor, so the
    // low D_W bits of a D_W-wide subtract are exact.
    rem_next = q_bit ? (shifted[D_W-1:0] - divisor) : shifted[D_W-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, one quotient bit per cycle.
// Optional feature: define SEQ_DIV_DIVZERO_EN to add the DivZero port and a
// fast path that finishes a divide-by-zero right at acceptance.
// Ports:
//   Clk      - clock, rising edge
//   Rst      - asynchronous active-high reset
//   Start    - begin a division (only looked at in IDLE)
//   Dividend - N_W-bit unsigned dividend, captured on the accepting edge
//   Divisor  - D_W-bit unsigned divisor, captured on the accepting edge
//   Q        - quotient register, updated only on completion
//   R        - remainder register, updated only on completion
//   Stop     - one-cycle completion pulse (high while in DONE)
//   DivZero  - divide-by-zero flag (SEQ_DIV_DIVZERO_EN only)
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned N_W = NW_DEFAULT,
  parameter int unsigned D_W = DW_DEFAULT
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Start,
  input  logic [N_W-1:0] Dividend,
  input  logic [D_W-1:0] Divisor,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           Stop
`ifdef SEQ_DIV_DIVZERO_EN
  ,
  output logic           DivZero
`endif
);

  localparam int unsigned CNT_W = cnt_width(N_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Shift register: remaining dividend bits leave at the top while quotient
  // bits enter at the bottom, so after N_W steps it holds the quotient.
  logic [N_W-1:0]   dvd_q, dvd_d;
  logic [D_W-1:0]   dsr_q, dsr_d;
  logic [D_W-1:0]   rem_q, rem_d;
  logic [N_W-1:0]   q_q, q_d;
  logic [D_W-1:0]   r_q, r_d;
`ifdef SEQ_DIV_DIVZERO_EN
  logic             dz_q, dz_d;
`endif

  logic [D_W-1:0]   step_rem;
  logic             step_q;

  div_step #(
    .D_W(D_W)
  ) u_step (
    .rem     (rem_q),
    .msb     (dvd_q[N_W-1]),
    .divisor (dsr_q),
    .rem_next(step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef SEQ_DIV_DIVZERO_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          dvd_d   = Dividend;
          dsr_d   = Divisor;
          rem_d   = '0;
          cnt_d   = CNT_W'(N_W - 1);
          state_d = StBusy;
`ifdef SEQ_DIV_DIVZERO_EN
          if (Divisor == '0) begin
            q_d     = '1;
            r_d     = Dividend[D_W-1:0];
            dz_d    = 1'b1;
            cnt_d   = '0;
            state_d = StDone;
          end
`endif
        end
      end
      StBusy: begin
        dvd_d = {dvd_q[N_W-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Publish the final step directly so Q/R are valid alongside Stop.
          q_d     = {dvd_q[N_W-2:0], step_q};
          r_d     = step_rem;
          cnt_d   = '0;
          state_d = StDone;
`ifdef SEQ_DIV_DIVZERO_EN
          dz_d    = 1'b0;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef SEQ_DIV_DIVZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef SEQ_DIV_DIVZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign Stop = (state_q == StDone);
`ifdef SEQ_DIV_DIVZERO_EN
  assign DivZero = dz_q;
`endif

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: self-checking bench for seq_div (default 16/8 widths).
// Directed vector table, hand-written multi-cycle sequences (ignored Start,
// abort by reset, Start held high) and random divisions against an
// arithmetic reference model. Honours SEQ_DIV_DIVZERO_EN if defined.
module tb_seq_div;

  localparam int unsigned N_W = 16;
  localparam int unsigned D_W = 8;

  logic           Clk = 1'b0;
  logic           Rst;
  logic           Start;
  logic [N_W-1:0] Dividend;
  logic [D_W-1:0] Divisor;
  logic [N_W-1:0] Q;
  logic [D_W-1:0] R;
  logic           Stop;
`ifdef SEQ_DIV_DIVZERO_EN
  logic           DivZero;
`endif

  int checks = 0;
  int errors = 0;

  // Last completed result as predicted by the model; Q/R must hold this while busy.
  logic [N_W-1:0] prev_q = '0;
  logic [D_W-1:0] prev_r = '0;

  always #5 Clk = ~Clk;

  seq_div #(
    .N_W(N_W),
    .D_W(D_W)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Dividend(Dividend),
    .Divisor (Divisor),
    .Q       (Q),
    .R       (R),
    .Stop    (Stop)
`ifdef SEQ_DIV_DIVZERO_EN
    ,
    .DivZero (DivZero)
`endif
  );

  typedef struct {
    logic [N_W-1:0] dvd;
    logic [D_W-1:0] dsr;
    logic [N_W-1:0] q;
    logic [D_W-1:0] r;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N_W-1:0] model_q(input logic [N_W-1:0] a, input logic [D_W-1:0] b);
    if (b == 0) return '1;
    return N_W'(int'(a) / int'(b));
  endfunction

  function automatic logic [D_W-1:0] model_r(input logic [N_W-1:0] a, input logic [D_W-1:0] b);
    if (b == 0) return a[D_W-1:0];
    return D_W'(int'(a) % int'(b));
  endfunction

  // Edges counted from the accepting edge (which is edge 1) to Stop.
  function automatic int exp_lat(input logic [D_W-1:0] b);
`ifdef SEQ_DIV_DIVZERO_EN
    if (b == 0) return 1;
`endif
    return N_W + 1;
  endfunction

  // Run one division from IDLE and check result, latency, pulse width and hold.
  task automatic run_div(input string tag, input logic [N_W-1:0] dvd, input logic [D_W-1:0] dsr,
                         input logic [N_W-1:0] eq, input logic [D_W-1:0] er);
    int lat;
    int hold_bad;
    bit seen;
    @(negedge Clk);
    Dividend = dvd;
    Divisor  = dsr;
    Start    = 1'b1;
    @(negedge Clk);
    Start    = 1'b0;
    Dividend = N_W'($urandom);
    Divisor  = D_W'($urandom);
    lat      = 1;
    seen     = 1'b0;
    hold_bad = 0;
    while (!seen && lat < 40) begin
      if (Stop) begin
        seen = 1'b1;
      end else begin
        if (Q !== prev_q || R !== prev_r) hold_bad++;
        @(negedge Clk);
        lat++;
      end
    end
    check({tag, "_latency"}, lat, exp_lat(dsr));
    check({tag, "_q"}, {16'd0, Q}, {16'd0, eq});
    check({tag, "_r"}, {24'd0, R}, {24'd0, er});
    check({tag, "_busy_hold"}, hold_bad, 0);
`ifdef SEQ_DIV_DIVZERO_EN
    check({tag, "_divzero"}, {31'd0, DivZero}, (dsr == 0) ? 1 : 0);
`endif
    @(negedge Clk);
    check({tag, "_stop_width"}, {31'd0, Stop}, 0);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    int pulses;
    int first;
    int gap;
    int hold_bad;
    logic [N_W-1:0] got_q;
    logic [D_W-1:0] got_r;
    logic [N_W-1:0] a;
    logic [D_W-1:0] b;

    Rst      = 1'b1;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;

    vecs.push_back('{dvd: 16'd42,    dsr: 8'd7,   q: 16'd6,     r: 8'd0});
    vecs.push_back('{dvd: 16'd1000,  dsr: 8'd13,  q: 16'd76,    r: 8'd12});
    vecs.push_back('{dvd: 16'd65535, dsr: 8'd255, q: 16'd257,   r: 8'd0});
    vecs.push_back('{dvd: 16'd3,     dsr: 8'd200, q: 16'd0,     r: 8'd3});
    vecs.push_back('{dvd: 16'd5,     dsr: 8'd0,   q: 16'hFFFF,  r: 8'd5});
    vecs.push_back('{dvd: 16'd0,     dsr: 8'd1,   q: 16'd0,     r: 8'd0});
    vecs.push_back('{dvd: 16'd65535, dsr: 8'd1,   q: 16'd65535, r: 8'd0});
    vecs.push_back('{dvd: 16'h1234,  dsr: 8'd0,   q: 16'hFFFF,  r: 8'h34});
    vecs.push_back('{dvd: 16'd255,   dsr: 8'd16,  q: 16'd15,    r: 8'd15});

    // Reset state
    repeat (2) @(negedge Clk);
    check("reset_q", {16'd0, Q}, 0);
    check("reset_r", {24'd0, R}, 0);
    check("reset_stop", {31'd0, Stop}, 0);
`ifdef SEQ_DIV_DIVZERO_EN
    check("reset_divzero", {31'd0, DivZero}, 0);
`endif
    Rst = 1'b0;
    @(negedge Clk);

    // Directed table
    foreach (vecs[i]) begin
      run_div($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dsr, vecs[i].q, vecs[i].r);
    end

    // Start re-pulsed mid-BUSY with new operands must be ignored, not queued
    @(negedge Clk);
    Dividend = 16'd1000;
    Divisor  = 8'd13;
    Start    = 1'b1;
    @(negedge Clk);
    Start  = 1'b0;
    pulses = 0;
    first  = -1;
    got_q  = '0;
    got_r  = '0;
    for (int k = 1; k <= 45; k++) begin
      if (Stop) begin
        pulses++;
        if (first < 0) begin
          first = k;
          got_q = Q;
          got_r = R;
        end
      end
      if (k == 5) begin
        Start    = 1'b1;
        Dividend = 16'd42;
        Divisor  = 8'd7;
      end else if (k == 6) begin
        Start = 1'b0;
      end
      @(negedge Clk);
    end
    check("ignore_start_pulses", pulses, 1);
    check("ignore_start_latency", first, 17);
    check("ignore_start_q", {16'd0, got_q}, 76);
    check("ignore_start_r", {24'd0, got_r}, 12);
    prev_q = 16'd76;
    prev_r = 8'd12;

    // Reset mid-division: abort without Stop, outputs cleared, Rst beats Start
    Dividend = 16'd1000;
    Divisor  = 8'd13;
    Start    = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (7) @(negedge Clk);
    Rst   = 1'b1;
    Start = 1'b1;
    #1;
    check("abort_rst_q", {16'd0, Q}, 0);
    check("abort_rst_r", {24'd0, R}, 0);
    check("abort_rst_stop", {31'd0, Stop}, 0);
    @(negedge Clk);
    check("abort_rst_stop_held", {31'd0, Stop}, 0);
    Start = 1'b0;
    @(negedge Clk);
    Rst    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge Clk);
      if (Stop) pulses++;
    end
    check("abort_no_stop", pulses, 0);
    check("abort_q_cleared", {16'd0, Q}, 0);
    prev_q = '0;
    prev_r = '0;
    run_div("after_abort", 16'd100, 8'd9, 16'd11, 8'd1);

    // Start held high for 40 cycles: back-to-back runs, pulses 18 cycles apart
    Dividend = 16'd42;
    Divisor  = 8'd7;
    Start    = 1'b1;
    pulses   = 0;
    first    = -1;
    gap      = -1;
    hold_bad = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge Clk);
      if (Stop) begin
        pulses++;
        if (first < 0) first = e;
        else if (gap < 0) gap = e - first;
      end
      if (first >= 0 && (Q !== 16'd6 || R !== 8'd0)) hold_bad++;
    end
    Start = 1'b0;
    check("held_start_pulses", pulses, 2);
    check("held_start_first", first, 17);
    check("held_start_gap", gap, 18);
    check("held_start_hold", hold_bad, 0);
    repeat (25) @(negedge Clk);
    prev_q = 16'd6;
    prev_r = 8'd0;

    // Random divisions against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      a = N_W'($urandom);
      if (i % 4 == 0) a = N_W'($urandom_range(0, 300));
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : D_W'($urandom_range(1, 255));
      run_div($sformatf("rand%0d", i), a, b, model_q(a, b), model_r(a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter N_W, default 16, meaning dividend and quotient width.
REQ-002 SHALL have parameter D_W, default 8, meaning divisor and remainder width.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port Rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port Start, input, 1, request to begin a division; sampled only in IDLE.
REQ-006 SHALL have port Dividend, input, N_W, unsigned dividend; sampled on the accepting edge only.
REQ-007 SHALL have port Divisor, input, D_W, unsigned divisor; sampled on the accepting edge only.
REQ-008 SHALL have port Q, output, N_W, quotient register.
REQ-009 SHALL have port R, output, D_W, remainder register.
REQ-010 SHALL have port Stop, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port DivZero, output, 1, divide-by-zero flag; present only per REQ-026.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: Start=1 at an edge SHALL latch Dividend/Divisor, clear the partial remainder, load iteration counter N_W-1, and go to BUSY.
REQ-014 BUSY: each edge SHALL perform one restoring step: shift {rem, next dividend MSB}; compare against Divisor at D_W+1 bits; subtract and shift in quotient bit 1 if >=, else shift in 0.
REQ-015 BUSY SHALL last exactly N_W cycles; the counter decrements each step; counter=0 goes to DONE.
REQ-016 DONE: Q/R SHALL be updated with final values; Stop SHALL be 1 for exactly this one cycle; next edge returns to IDLE.
REQ-017 Latency SHALL be N_W+1 edges from the accepting edge to Stop=1 (17 for defaults).
REQ-018 Q, R and DivZero SHALL hold their values from DONE until the next DONE or reset; they SHALL NOT show intermediate values during BUSY.
REQ-019 Start in BUSY or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-020 Start held high continuously SHALL start a new division on the first edge in IDLE after DONE.
REQ-021 Results SHALL satisfy Dividend = Q*Divisor + R with R < Divisor, for any nonzero Divisor.
REQ-022 Divisor=0 without the REQ-026 feature SHALL run the full latency and yield Q=all ones, R=Dividend[D_W-1:0].

Reset
REQ-023 Rst=1 SHALL immediately force state IDLE, Q=0, R=0, Stop=0, DivZero=0, counter=0, and clear internal registers.
REQ-024 Rst asserted mid-division SHALL abort the operation with no Stop pulse; the first Start after release begins a fresh division.
REQ-025 Rst=1 SHALL override Start on the same edge.

Configuration
REQ-026 With macro SEQ_DIV_DIVZERO_EN defined: port DivZero SHALL exist; Divisor=0 at acceptance SHALL skip BUSY, go directly to DONE (Stop on the 1st edge after acceptance) with Q=all ones, R=Dividend[D_W-1:0], DivZero=1; DivZero SHALL be 0 for any nonzero-divisor result.
REQ-027 Without SEQ_DIV_DIVZERO_EN: port DivZero SHALL be absent and REQ-022 SHALL apply.

Structure
REQ-028 Package seq_div_pkg SHALL hold the default widths, the FSM state type/encoding, and the counter width constant ($clog2(N_W)).
REQ-029 The combinational restoring step (shift, compare, subtract, quotient bit) SHALL be a sub-module div_step, instantiated once.

Verification
REQ-030 Dividend=42, Divisor=7, Start pulsed 1 cycle -> Stop on 17th edge, Q=6, R=0 (inverse of the 6x7 multiply case).
REQ-031 Dividend=1000, Divisor=13 -> Q=76, R=12; Dividend=65535, Divisor=255 -> Q=257, R=0; Dividend=3, Divisor=200 -> Q=0, R=3.
REQ-032 Dividend=5, Divisor=0 -> with macro: Stop 1 edge after acceptance, Q=16'hFFFF, R=5, DivZero=1; without: Stop on 17th edge, same Q/R.
REQ-033 Start re-pulsed at cycle 5 of BUSY with new operands -> ignored; original result delivered at the normal time with a single Stop pulse.
REQ-034 Rst raised at cycle 8 of BUSY, released, then a 100/9 request -> no Stop from the aborted run; outputs 0 during reset; later Q=11, R=1.
REQ-035 Start held high for 40 cycles with 42/7 -> back-to-back divisions, Stop pulses 18 cycles apart, results unchanged between pulses.
